// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug monitor.
//   dbg_state_e    : dump FSM states
//   dbg_rec_t      : one dump record {arch, preg, data} at the default widths
//   dbg_trace_t    : one mispredict trace entry {pc, stamp} at the default widths
//   DBG_DUMP_LIST_DEFAULT : default register list (x1, x9, x10, x11, x29)
//   dbg_list_entry : selects a 5-bit entry from a packed dump list
package dbg_pkg;

  localparam int unsigned DBG_ARCH_W = 5;
  localparam int unsigned DBG_PREG_W = 7;
  localparam int unsigned DBG_CNT_W  = 32;

  // Entry 0 sits in bits [4:0] and is dumped first.
  localparam logic [24:0] DBG_DUMP_LIST_DEFAULT = {5'd29, 5'd11, 5'd10, 5'd9, 5'd1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAP,
    ST_PRF,
    ST_EMIT
  } dbg_state_e;

  typedef struct packed {
    logic [DBG_ARCH_W-1:0] arch;
    logic [DBG_PREG_W-1:0] preg;
    logic [31:0]           data;
  } dbg_rec_t;

  typedef struct packed {
    logic [31:0]          pc;
    logic [DBG_CNT_W-1:0] stamp;
  } dbg_trace_t;

  // list holds up to 32 entries of 5 bits; narrower lists are zero-extended.
  function automatic logic [4:0] dbg_list_entry(input logic [159:0] list,
                                                input logic [4:0]   idx);
    return list[int'(idx)*5 +: 5];
  endfunction

endpackage

// File: rtl/dbg_trace_fifo.sv
// Circular FIFO that drops pushes when full and latches a sticky overflow flag.
//   clk, reset     : clock, asynchronous active-high reset
//   push, push_data: write request and data
//   pop            : read request (ignored when empty)
//   head           : head entry, combinational, 0 when empty
//   empty          : FIFO holds no entries
//   overflow       : a push was dropped since reset
module dbg_trace_fifo
  import dbg_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              full;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dbg_monitor.sv
// On-chip debug monitor: saturating commit/mispredict counters, a register
// dump engine that walks DUMP_LIST through the rename map and PRF and streams
// (arch, preg, data) records over valid/ready, and an optional mispredict
// trace FIFO (build with DBG_TRACE_EN defined).
//   clk, reset                 : clock, asynchronous active-high reset
//   mispredict, mispredict_pc  : mispredict strobe and branch PC
//   commit_valid               : one instruction retired
//   dump_req                   : start a dump (ignored while busy)
//   map_raddr / map_rdata      : rename-map read port (combinational)
//   prf_raddr / prf_rdata      : PRF read port (combinational)
//   dump_valid/ready/arch/preg/data/last, dump_busy : record stream
//   commit_cnt, mispredict_cnt : saturating counters
//   trace_rd_en, trace_pc, trace_stamp, trace_empty, trace_overflow :
//                                trace FIFO (DBG_TRACE_EN only)
module dbg_monitor
  import dbg_pkg::*;
#(
  parameter int unsigned                NUM_DUMP    = 5,
  parameter logic [NUM_DUMP*5-1:0]      DUMP_LIST   = DBG_DUMP_LIST_DEFAULT,
  parameter int unsigned                PREG_W      = 7,
  parameter int unsigned                CNT_W       = 32,
  parameter int unsigned                TRACE_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mispredict,
  input  logic [31:0]       mispredict_pc,
  input  logic              commit_valid,
  input  logic              dump_req,
  output logic [4:0]        map_raddr,
  input  logic [PREG_W-1:0] map_rdata,
  output logic [PREG_W-1:0] prf_raddr,
  input  logic [31:0]       prf_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [4:0]        dump_arch,
  output logic [PREG_W-1:0] dump_preg,
  output logic [31:0]       dump_data,
  output logic              dump_last,
  output logic              dump_busy,
  output logic [CNT_W-1:0]  commit_cnt,
  output logic [CNT_W-1:0]  mispredict_cnt
`ifdef DBG_TRACE_EN
  ,
  input  logic              trace_rd_en,
  output logic [31:0]       trace_pc,
  output logic [CNT_W-1:0]  trace_stamp,
  output logic              trace_empty,
  output logic              trace_overflow
`endif
);

  dbg_state_e state;
  dbg_state_e state_nxt;
  logic [4:0] idx;
  logic       last_idx;
  logic [4:0] list_arch;

  assign last_idx  = (idx == 5'(NUM_DUMP - 1));
  assign list_arch = dbg_list_entry(160'(DUMP_LIST), idx);

  // ---------------- counters ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (commit_valid && (commit_cnt != '1))     commit_cnt     <= commit_cnt + 1'b1;
      if (mispredict && (mispredict_cnt != '1))   mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

  // ---------------- dump FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (dump_req) state_nxt = ST_MAP;
      ST_MAP:  state_nxt = ST_PRF;
      ST_PRF:  state_nxt = ST_EMIT;
      ST_EMIT: if (dump_ready) state_nxt = last_idx ? ST_IDLE : ST_MAP;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    map_raddr  = '0;
    prf_raddr  = '0;
    dump_valid = 1'b0;
    dump_last  = 1'b0;
    dump_busy  = (state != ST_IDLE);
    case (state)
      ST_MAP:  map_raddr = list_arch;
      ST_PRF:  prf_raddr = dump_preg;
      ST_EMIT: begin
        dump_valid = 1'b1;
        dump_last  = last_idx;
      end
      default: ;
    endcase
  end

  // Record registers only load in MAP/PRF, so they hold through an EMIT stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      dump_arch <= '0;
      dump_preg <= '0;
      dump_data <= '0;
    end else begin
      case (state)
        ST_IDLE: if (dump_req) idx <= '0;
        ST_MAP: begin
          dump_arch <= list_arch;
          dump_preg <= map_rdata;
        end
        ST_PRF:  dump_data <= prf_rdata;
        ST_EMIT: if (dump_ready && !last_idx) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef DBG_TRACE_EN
  // ---------------- mispredict trace ----------------
  logic [CNT_W-1:0]    cycle_cnt;
  logic [32+CNT_W-1:0] trace_head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + 1'b1;
  end

  dbg_trace_fifo #(
    .DEPTH  (TRACE_DEPTH),
    .DATA_W (32 + CNT_W)
  ) u_trace_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (mispredict),
    .push_data ({mispredict_pc, cycle_cnt}),
    .pop       (trace_rd_en),
    .head      (trace_head),
    .empty     (trace_empty),
    .overflow  (trace_overflow)
  );

  assign trace_pc    = trace_head[32+CNT_W-1:CNT_W];
  assign trace_stamp = trace_head[CNT_W-1:0];
`else
  logic unused_pc;
  assign unused_pc = ^mispredict_pc;
`endif

endmodule

// File: tb/tb_dbg_monitor.sv
// Directed bench for dbg_monitor: dump sequencing and stalls, counters and
// saturation (second instance with CNT_W=4), reset mid-dump, and the trace
// FIFO when built with DBG_TRACE_EN.
module tb_dbg_monitor;
  import dbg_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mispredict = 1'b0;
  logic [31:0] mispredict_pc = '0;
  logic        commit_valid = 1'b0;
  logic        dump_req = 1'b0;
  logic        dump_ready = 1'b0;
  logic [4:0]  map_raddr;
  logic [6:0]  map_rdata;
  logic [6:0]  prf_raddr;
  logic [31:0] prf_rdata;
  logic        dump_valid;
  logic [4:0]  dump_arch;
  logic [6:0]  dump_preg;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        dump_busy;
  logic [31:0] commit_cnt;
  logic [31:0] mispredict_cnt;

  logic [4:0]  s_map_raddr;
  logic [6:0]  s_prf_raddr;
  logic        s_dump_valid;
  logic [4:0]  s_dump_arch;
  logic [6:0]  s_dump_preg;
  logic [31:0] s_dump_data;
  logic        s_dump_last;
  logic        s_dump_busy;
  logic [3:0]  s_commit_cnt;
  logic [3:0]  s_mispredict_cnt;

`ifdef DBG_TRACE_EN
  logic        trace_rd_en = 1'b0;
  logic [31:0] trace_pc;
  logic [31:0] trace_stamp;
  logic        trace_empty;
  logic        trace_overflow;
  logic [31:0] s_trace_pc;
  logic [3:0]  s_trace_stamp;
  logic        s_trace_empty;
  logic        s_trace_overflow;
`endif

  always #5 clk = ~clk;

  // Rename map and PRF models.
  logic [6:0]  map_mem [32];
  logic [31:0] prf_mem [128];
  assign map_rdata = map_mem[map_raddr];
  assign prf_rdata = prf_mem[prf_raddr];

  dbg_monitor dut (
    .clk            (clk),
    .reset          (reset),
    .mispredict     (mispredict),
    .mispredict_pc  (mispredict_pc),
    .commit_valid   (commit_valid),
    .dump_req       (dump_req),
    .map_raddr      (map_raddr),
    .map_rdata      (map_rdata),
    .prf_raddr      (prf_raddr),
    .prf_rdata      (prf_rdata),
    .dump_valid     (dump_valid),
    .dump_ready     (dump_ready),
    .dump_arch      (dump_arch),
    .dump_preg      (dump_preg),
    .dump_data      (dump_data),
    .dump_last      (dump_last),
    .dump_busy      (dump_busy),
    .commit_cnt     (commit_cnt),
    .mispredict_cnt (mispredict_cnt)
`ifdef DBG_TRACE_EN
    ,
    .trace_rd_en    (trace_rd_en),
    .trace_pc       (trace_pc),
    .trace_stamp    (trace_stamp),
    .trace_empty    (trace_empty),
    .trace_overflow (trace_overflow)
`endif
  );

  dbg_monitor #(.CNT_W(4)) dut_small (
    .clk            (clk),
    .reset          (reset),
    .mispredict     (mispredict),
    .mispredict_pc  (mispredict_pc),
    .commit_valid   (commit_valid),
    .dump_req       (1'b0),
    .map_raddr      (s_map_raddr),
    .map_rdata      (map_rdata),
    .prf_raddr      (s_prf_raddr),
    .prf_rdata      (prf_rdata),
    .dump_valid     (s_dump_valid),
    .dump_ready     (1'b1),
    .dump_arch      (s_dump_arch),
    .dump_preg      (s_dump_preg),
    .dump_data      (s_dump_data),
    .dump_last      (s_dump_last),
    .dump_busy      (s_dump_busy),
    .commit_cnt     (s_commit_cnt),
    .mispredict_cnt (s_mispredict_cnt)
`ifdef DBG_TRACE_EN
    ,
    .trace_rd_en    (1'b0),
    .trace_pc       (s_trace_pc),
    .trace_stamp    (s_trace_stamp),
    .trace_empty    (s_trace_empty),
    .trace_overflow (s_trace_overflow)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  dbg_rec_t    exp_rec [5];
  int unsigned n_rec;
  logic        last_seen;
  logic        any_out;
`ifdef DBG_TRACE_EN
  logic [31:0] last_pc;
  int unsigned n_pop;
`endif

  initial begin
    for (int unsigned i = 0; i < 32; i++)  map_mem[i] = 7'(i);
    for (int unsigned i = 0; i < 128; i++) prf_mem[i] = 32'h5500_0000 + i;
    map_mem[1]  = 7'd33;  prf_mem[33] = 32'h0000_00AA;
    map_mem[9]  = 7'd20;  prf_mem[20] = 32'h0000_0909;
    map_mem[10] = 7'd21;  prf_mem[21] = 32'h0000_0A0A;
    map_mem[11] = 7'd22;  prf_mem[22] = 32'h0000_0B0B;
    map_mem[29] = 7'd40;  prf_mem[40] = 32'hDEAD_BEEF;
    exp_rec[0] = '{arch: 5'd1,  preg: 7'd33, data: 32'h0000_00AA};
    exp_rec[1] = '{arch: 5'd9,  preg: 7'd20, data: 32'h0000_0909};
    exp_rec[2] = '{arch: 5'd10, preg: 7'd21, data: 32'h0000_0A0A};
    exp_rec[3] = '{arch: 5'd11, preg: 7'd22, data: 32'h0000_0B0B};
    exp_rec[4] = '{arch: 5'd29, preg: 7'd40, data: 32'hDEAD_BEEF};

    // Reset state.
    #1 reset = 1'b1;
    #1;
    check("rst_busy",  dump_busy, 0);
    check("rst_valid", dump_valid, 0);
    check("rst_last",  dump_last, 0);
    check("rst_rec",   {dump_arch, dump_preg, dump_data}, 0);
    check("rst_addr",  {map_raddr, prf_raddr}, 0);
    check("rst_cnt",   {commit_cnt, mispredict_cnt}, 0);
`ifdef DBG_TRACE_EN
    check("rst_tempty", trace_empty, 1);
    check("rst_tovf",   trace_overflow, 0);
    check("rst_thead",  {trace_pc, trace_stamp}, 0);
`endif
    tick();
    tick();
    reset = 1'b0;

    // Full dump, consumer always ready: records at t+3, t+6, ..., t+15.
    dump_ready = 1'b1;
    dump_req   = 1'b1;
    for (int unsigned r = 0; r < 5; r++) begin
      tick();
      dump_req = 1'b0;
      check("map_addr",  map_raddr, exp_rec[r].arch);
      check("map_valid", {dump_busy, dump_valid}, 2'b10);
      check("map_prf0",  prf_raddr, 0);
      tick();
      check("prf_addr",  prf_raddr, exp_rec[r].preg);
      check("prf_map0",  map_raddr, 0);
      check("prf_valid", dump_valid, 0);
      tick();
      check("emit_valid", dump_valid, 1);
      check("emit_rec",   {dump_arch, dump_preg, dump_data}, exp_rec[r]);
      check("emit_last",  dump_last, (r == 4));
    end
    tick();
    check("done_busy",  dump_busy, 0);
    check("done_valid", dump_valid, 0);

    // Consumer stall in EMIT; a dump_req during the stall must be ignored.
    dump_ready = 1'b0;
    dump_req   = 1'b1;
    tick();
    dump_req = 1'b0;
    tick();
    tick();
    check("stall_valid0", dump_valid, 1);
    for (int unsigned k = 0; k < 4; k++) begin
      dump_req = (k == 1);
      tick();
      check("stall_hold",  {dump_valid, dump_last, dump_arch, dump_preg, dump_data},
            {1'b1, 1'b0, exp_rec[0]});
    end
    dump_req   = 1'b0;
    dump_ready = 1'b1;
    n_rec      = 0;
    last_seen  = 1'b0;
    for (int unsigned c = 0; c < 60 && dump_busy; c++) begin
      if (dump_valid) begin
        if (n_rec < 5) check("stall_rec", {dump_arch, dump_preg, dump_data}, exp_rec[n_rec]);
        n_rec++;
        last_seen = dump_last;
      end
      tick();
    end
    check("stall_nrec", n_rec, 5);
    check("stall_last", last_seen, 1);
    check("stall_idle", dump_busy, 0);
    tick();
    tick();
    check("stall_noreq", dump_busy, 0);

    // Mispredicts: 10 pushes at 0x100+4k, no pops.
    do_reset();
    for (int unsigned k = 0; k < 10; k++) begin
      mispredict    = 1'b1;
      mispredict_pc = 32'h100 + 4 * k;
      tick();
    end
    mispredict = 1'b0;
    check("mp_cnt",   mispredict_cnt, 10);
    check("mp_cnt_s", s_mispredict_cnt, 10);
`ifdef DBG_TRACE_EN
    check("tr_ovf",   trace_overflow, 1);
    check("tr_empty", trace_empty, 0);
    trace_rd_en = 1'b1;
    for (int unsigned k = 0; k < 8; k++) begin
      check("tr_pc",    trace_pc, 32'h100 + 4 * k);
      check("tr_stamp", trace_stamp, k);
      tick();
    end
    check("tr_drained", {trace_empty, trace_pc, trace_stamp}, {1'b1, 64'h0});
    tick();
    check("tr_pop_empty", {trace_empty, trace_overflow}, 2'b11);
    trace_rd_en = 1'b0;

    // Full FIFO: simultaneous push and pop.
    do_reset();
    for (int unsigned k = 0; k < 8; k++) begin
      mispredict    = 1'b1;
      mispredict_pc = 32'h100 + 4 * k;
      tick();
    end
    check("full_ovf",  trace_overflow, 0);
    check("full_head", trace_pc, 32'h100);
    mispredict_pc = 32'h200;
    trace_rd_en   = 1'b1;
    tick();
    mispredict  = 1'b0;
    trace_rd_en = 1'b0;
    check("pp_head", trace_pc, 32'h104);
    check("pp_ovf",  trace_overflow, 0);
    n_pop   = 0;
    last_pc = '0;
    for (int unsigned c = 0; c < 20 && !trace_empty; c++) begin
      last_pc     = trace_pc;
      trace_rd_en = 1'b1;
      tick();
      n_pop++;
    end
    trace_rd_en = 1'b0;
    check("pp_count",   n_pop, 8);
    check("pp_last_pc", last_pc, 32'h200);
`endif

    // Commit counter, including 4-bit saturation.
    commit_valid = 1'b1;
    tick();
    check("cm_first", commit_cnt, 1);
    for (int unsigned k = 1; k < 20; k++) tick();
    commit_valid = 1'b0;
    check("cm_20",  commit_cnt, 20);
    check("cm_sat", s_commit_cnt, 4'hF);
    tick();
    check("cm_hold", {commit_cnt, 4'(s_commit_cnt)}, {32'd20, 4'hF});

    // Reset during PRF of the second record.
    dump_ready = 1'b1;
    dump_req   = 1'b1;
    tick();
    dump_req = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("mid_prf", prf_raddr, 7'd20);
    reset = 1'b1;
    #1;
    check("mid_busy",  dump_busy, 0);
    check("mid_valid", {dump_valid, dump_last}, 0);
    check("mid_prf0",  prf_raddr, 0);
    check("mid_cnt",   {commit_cnt, mispredict_cnt}, 0);
    check("mid_cnt_s", s_commit_cnt, 0);
`ifdef DBG_TRACE_EN
    check("mid_tempty", {trace_empty, trace_overflow}, 2'b10);
`endif
    tick();
    reset   = 1'b0;
    any_out = 1'b0;
    for (int unsigned c = 0; c < 8; c++) begin
      any_out = any_out | dump_valid | dump_last | dump_busy;
      tick();
    end
    check("mid_quiet", any_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dbg_monitor.md
# dbg_monitor

Parametrised on-chip debug monitor for the out-of-order core: counts commits and mispredicts, logs mispredict PCs with cycle stamps, and on request walks a configurable list of architectural registers through the rename map and PRF, streaming (arch, phys, value) records over a valid/ready port. It sits beside `processor`, snooping its mispredict and commit strobes and sharing a spare read port on the rename map and the PRF. It replaces ad-hoc bench-side register dumps with a synthesizable, bench- and FPGA-visible mechanism.

## Interface
Parameters:
- NUM_DUMP, 5, number of architectural registers per dump (1..32)
- DUMP_LIST, {5'd29,5'd11,5'd10,5'd9,5'd1}, packed NUM_DUMP×5 list; entry 0 = bits [4:0], dumped first
- PREG_W, 7, physical register index width
- CNT_W, 32, counter and stamp width
- TRACE_DEPTH, 8, mispredict trace FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- mispredict  in  1  one-cycle mispredict strobe
- mispredict_pc  in  32  PC of mispredicting branch, valid with mispredict
- commit_valid  in  1  one instruction retired this cycle
- dump_req  in  1  start-dump pulse
- map_raddr  out  5  rename-map read address
- map_rdata  in  PREG_W  combinational map read data
- prf_raddr  out  PREG_W  PRF read address
- prf_rdata  in  32  combinational PRF read data
- dump_valid  out  1  record valid
- dump_ready  in  1  consumer accepts record
- dump_arch  out  5  architectural index
- dump_preg  out  PREG_W  mapped physical index
- dump_data  out  32  register value
- dump_last  out  1  final record of the dump
- dump_busy  out  1  dump FSM not IDLE
- commit_cnt  out  CNT_W  retired-instruction count
- mispredict_cnt  out  CNT_W  mispredict count
- trace_rd_en  in  1  pop one trace entry (`DBG_TRACE_EN`)
- trace_pc, trace_stamp  out  32, CNT_W  head entry (`DBG_TRACE_EN`)
- trace_empty, trace_overflow  out  1, 1  FIFO empty; sticky drop flag (`DBG_TRACE_EN`)

## Operation
- Counters: commit_cnt and mispredict_cnt increment by 1 on their strobes and saturate at all-ones. The internal cycle counter increments every cycle and wraps.
- Dump FSM states are IDLE, MAP, PRF, EMIT.
  - IDLE: on dump_req, idx←0, go to MAP. dump_req is ignored while busy.
  - MAP: map_raddr=DUMP_LIST[idx]; register map_rdata into dump_preg and the arch index into dump_arch; go to PRF.
  - PRF: prf_raddr=dump_preg; register prf_rdata into dump_data; go to EMIT.
  - EMIT: dump_valid=1 and all dump_* outputs are held stable until dump_ready. On handshake: if idx==NUM_DUMP-1, go to IDLE; otherwise idx+1, go to MAP.
  - dump_last=1 only in EMIT with idx==NUM_DUMP-1.
- The snapshot is per-record, not atomic. Each record reflects the map and PRF at its own MAP/PRF cycle.
- map_raddr and prf_raddr drive 0 outside MAP and PRF respectively.
- Trace FIFO: a mispredict pushes {mispredict_pc, cycle}. trace_rd_en pops when not empty. Pop on empty is ignored.
  - Push when full drops the new entry and sets trace_overflow. trace_overflow stays set until reset.
  - Push and pop in the same cycle when full: both happen and overflow is not set.
  - Pointers are log2(TRACE_DEPTH)+1 bits with a wrap bit.
  - trace_pc and trace_stamp show the head entry combinationally. They read 0 when empty.

## Timing
- Reset (async assert, sync release): FSM=IDLE, idx=0, all counters 0, FIFO empty, trace_overflow=0. All outputs 0, except trace_empty=1.
- Reset mid-dump aborts the dump immediately. No dump_last is produced.
- A dump_req sampled in cycle t gives MAP in t+1, PRF in t+2, and first dump_valid in t+3.
- Each record takes 3 cycles plus consumer stall. A full dump with dump_ready held at 1 takes 3·NUM_DUMP cycles; dump_busy falls the cycle after the last handshake.
- Counter and FIFO updates are visible the cycle after the strobe. A pop in cycle t shows the new head in t+1.

## Configuration
- Macro `DBG_TRACE_EN`.
- Defined: the trace FIFO and its ports exist.
- Undefined: the FIFO, the cycle counter and the trace_* ports are removed. The counters and dump FSM are unchanged.

## Structure
- Package `dbg_pkg` holds:
  - dump FSM state enum
  - `dbg_rec_t` {arch, preg, data}
  - `dbg_trace_t` {pc, stamp}
  - default DUMP_LIST constant
- One sub-module, `dbg_trace_fifo`, a parametrised circular FIFO with drop-on-full and a sticky overflow flag.

## Test plan
- Map x1→p33 (PRF[33]=0x0000_00AA) and x29→p40 (PRF[40]=0xDEAD_BEEF); pulse dump_req with dump_ready=1 -> 5 records at cycles t+3, t+6 … t+15; first record {1,33,0xAA}; last record {29,40,0xDEADBEEF} with dump_last=1.
- Hold dump_ready=0 for 4 cycles in EMIT -> outputs stable; a dump_req during this is ignored; exactly 5 records total.
- 10 mispredicts at PCs 0x100+4k with TRACE_DEPTH=8, no pops -> 8 entries, PCs 0x100..0x11C, stamps increasing, trace_overflow=1, mispredict_cnt=10.
- FIFO full, push and pop in the same cycle -> head advances, count stays 8, overflow unchanged.
- CNT_W=4, 20 commits -> commit_cnt saturates at 15.
- Assert reset during PRF of record 2 -> dump_busy=0 and dump_valid=0 immediately; counters 0; trace_empty=1.
